// File: rtl/sdram_feeder_pkg.sv
// Shared types and helpers for the SDRAM block feeder.
// Optional block header word is enabled by defining SDRAM_FEEDER_HEADER_EN.
package sdram_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    HDR       = 3'd2,
    STREAM    = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  localparam logic [15:0] HDR_TAG = 16'hB10C;

`ifdef SDRAM_FEEDER_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  // Bytes occupied by one block in SDRAM, including the optional header word.
  function automatic logic [31:0] blk_bytes(input int unsigned words, input bit hdr);
    return 32'((words + (hdr ? 32'd1 : 32'd0)) * 32'd4);
  endfunction

endpackage

// File: rtl/sdram_ring_addr_gen.sv
// Ring block index: advances on a strobe, wraps after RING_BLOCKS blocks and
// presents the byte base address of the current block.
module sdram_ring_addr_gen #(
  parameter logic [31:0] RING_BASE   = 32'h0000_0000,
  parameter int unsigned RING_BLOCKS = 1024,
  parameter logic [31:0] STRIDE      = 32'd1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [31:0] base,
  output logic        wrap
);

  localparam int IDX_W = (RING_BLOCKS > 1) ? $clog2(RING_BLOCKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RING_BLOCKS - 1);

  logic [IDX_W-1:0] blk_idx;

  assign wrap = advance && (blk_idx == LAST_IDX);
  assign base = RING_BASE + 32'(blk_idx) * STRIDE;

  always_ff @(posedge clk) begin
    if (reset) begin
      blk_idx <= '0;
    end else if (advance) begin
      blk_idx <= wrap ? '0 : blk_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/sdram_block_feeder.sv
// Packs a 32-bit sample stream into fixed-size blocks for the SDRAM write master.
// Define SDRAM_FEEDER_HEADER_EN to prefix each block with a {B10C, blk_count} header.
//
// Handshake: a sample transfers on a rising clk_clk edge where in_valid & in_ready;
// upstream holds in_valid/in_data stable until then. mst_write_buffer is the same
// transfer forwarded combinationally, so mst_buffer_full stalls upstream directly.
module sdram_block_feeder
  import sdram_feeder_pkg::*;
#(
  parameter int unsigned BLOCK_WORDS = 256,
  parameter logic [31:0] RING_BASE   = 32'h0000_0000,
  parameter int unsigned RING_BLOCKS = 1024
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        enable,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        mst_fixed_location,
  output logic [31:0] mst_write_base,
  output logic [31:0] mst_write_length,
  output logic        mst_go,
  input  logic        mst_done,
  output logic        mst_write_buffer,
  output logic [31:0] mst_buffer_data,
  input  logic        mst_buffer_full,
  output logic        busy,
  output logic [31:0] blk_count,
  output logic        ring_wrap,
  output state_t      dbg_state
);

  localparam logic [31:0] BLK_LEN = blk_bytes(BLOCK_WORDS, HDR_EN);
  localparam int CNT_W = $clog2(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] word_cnt;
  logic             advance;
  logic [31:0]      ring_base;

  sdram_ring_addr_gen #(
    .RING_BASE  (RING_BASE),
    .RING_BLOCKS(RING_BLOCKS),
    .STRIDE     (BLK_LEN)
  ) u_ring (
    .clk    (clk_clk),
    .reset  (reset_reset),
    .advance(advance),
    .base   (ring_base),
    .wrap   (ring_wrap)
  );

  assign mst_fixed_location = 1'b0;
  assign busy               = (state != IDLE);
  assign dbg_state          = state;

  always_comb begin
    state_nxt        = state;
    in_ready         = 1'b0;
    mst_write_buffer = 1'b0;
    mst_buffer_data  = '0;
    advance          = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = LAUNCH;
      end
      LAUNCH: begin
`ifdef SDRAM_FEEDER_HEADER_EN
        state_nxt = HDR;
`else
        state_nxt = STREAM;
`endif
      end
`ifdef SDRAM_FEEDER_HEADER_EN
      HDR: begin
        mst_buffer_data  = {HDR_TAG, blk_count[15:0]};
        mst_write_buffer = ~mst_buffer_full;
        if (!mst_buffer_full) state_nxt = STREAM;
      end
`endif
      STREAM: begin
        in_ready         = ~mst_buffer_full;
        mst_buffer_data  = in_data;
        mst_write_buffer = in_valid & ~mst_buffer_full;
        if (in_valid && !mst_buffer_full && (word_cnt == LAST_WORD)) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (mst_done) begin
          advance   = 1'b1;
          state_nxt = enable ? LAUNCH : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Base/length are captured while in LAUNCH and go is registered from LAUNCH,
  // so the master sees go together with the new base and length.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state            <= IDLE;
      word_cnt         <= '0;
      blk_count        <= '0;
      mst_go           <= 1'b0;
      mst_write_base   <= RING_BASE;
      mst_write_length <= BLK_LEN;
    end else begin
      state  <= state_nxt;
      mst_go <= (state == LAUNCH);
      if (state == LAUNCH) begin
        mst_write_base   <= ring_base;
        mst_write_length <= BLK_LEN;
      end
      if (state == STREAM && mst_write_buffer) begin
        word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + CNT_W'(1);
      end
      if (advance) blk_count <= blk_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_sdram_block_feeder.sv
// Scoreboard bench for sdram_block_feeder with BLOCK_WORDS=4, RING_BLOCKS=2.
module tb_sdram_block_feeder;
  import sdram_feeder_pkg::*;

  localparam int unsigned BW = 4;
  localparam int unsigned RB = 2;
`ifdef SDRAM_FEEDER_HEADER_EN
  localparam int unsigned WPB = BW + 1;
`else
  localparam int unsigned WPB = BW;
`endif
  localparam logic [31:0] LEN = 32'(WPB * 4);

  logic        clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        enable = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        mst_fixed_location;
  logic [31:0] mst_write_base;
  logic [31:0] mst_write_length;
  logic        mst_go;
  logic        mst_done = 1'b0;
  logic        mst_write_buffer;
  logic [31:0] mst_buffer_data;
  logic        mst_buffer_full = 1'b0;
  logic        busy;
  logic [31:0] blk_count;
  logic        ring_wrap;
  state_t      dbg_state;

  logic [31:0] exp_q[$];
  logic [31:0] exp_base_q[$];
  int          tests = 0;
  int          failed = 0;
  int          wrap_cnt = 0;

  sdram_block_feeder #(
    .BLOCK_WORDS(BW),
    .RING_BASE  (32'h0000_0000),
    .RING_BLOCKS(RB)
  ) dut (
    .clk_clk           (clk),
    .reset_reset       (reset_reset),
    .enable            (enable),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .mst_fixed_location(mst_fixed_location),
    .mst_write_base    (mst_write_base),
    .mst_write_length  (mst_write_length),
    .mst_go            (mst_go),
    .mst_done          (mst_done),
    .mst_write_buffer  (mst_write_buffer),
    .mst_buffer_data   (mst_buffer_data),
    .mst_buffer_full   (mst_buffer_full),
    .busy              (busy),
    .blk_count         (blk_count),
    .ring_wrap         (ring_wrap),
    .dbg_state         (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic empty_pop_fail(input string name);
    tests++;
    failed++;
    $display("FAIL %s: DUT output with empty expected queue", name);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or a go.
  always @(negedge clk) begin
    if (mst_write_buffer) begin
      if (exp_q.size() == 0) empty_pop_fail("write_data");
      else check("write_data", mst_buffer_data, exp_q.pop_front());
    end
    if (mst_go) begin
      if (exp_base_q.size() == 0) empty_pop_fail("go_base");
      else check("go_base", mst_write_base, exp_base_q.pop_front());
      check("go_length", mst_write_length, LEN);
    end
    if (ring_wrap) wrap_cnt++;
  end

  // Master model: pulses done three cycles after the last word of each block.
  initial begin
    int wcnt = 0;
    forever begin
      @(negedge clk);
      if (reset_reset) begin
        wcnt = 0;
      end else if (mst_write_buffer) begin
        wcnt++;
        if (wcnt == int'(WPB)) begin
          wcnt = 0;
          repeat (3) @(posedge clk);
          #1 mst_done = 1'b1;
          @(posedge clk);
          #1 mst_done = 1'b0;
        end
      end
    end
  end

  // drivers
  task automatic start_block(input int unsigned idx, input logic [31:0] cnt);
    exp_base_q.push_back(32'(idx * WPB * 4));
`ifdef SDRAM_FEEDER_HEADER_EN
    exp_q.push_back({16'hB10C, cnt[15:0]});
`else
    if (cnt[31]) exp_q.push_back(32'hDEAD_BEEF);
`endif
  endtask

  task automatic send_word(input logic [31:0] d);
    int n = 0;
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(d);
    while (!ok && n < 200) begin
      @(negedge clk);
      n++;
      ok = in_ready;
    end
    if (!ok) begin
      tests++;
      failed++;
      $display("FAIL send_word: word %h not accepted within 200 cycles", d);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_go", 32'(mst_go), 32'd0);
    check("rst_write", 32'(mst_write_buffer), 32'd0);
    check("rst_data", mst_buffer_data, 32'd0);
    check("rst_blk_count", blk_count, 32'd0);
    check("rst_wrap", 32'(ring_wrap), 32'd0);
    check("rst_base", mst_write_base, 32'd0);
    check("rst_length", mst_write_length, LEN);
    check("fixed_loc", 32'(mst_fixed_location), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // two back-to-back blocks
    @(posedge clk);
    #1 enable = 1'b1;
    start_block(0, 32'd0);
    for (int i = 1; i <= 4; i++) send_word(32'(i));
    start_block(1, 32'd1);
    send_word(32'd5);
    check("blk_count_after_b0", blk_count, 32'd1);
    check("wrap_after_b0", 32'(wrap_cnt), 32'd0);
    for (int i = 6; i <= 8; i++) send_word(32'(i));

    // third block wraps to base 0; backpressure held mid-block
    start_block(0, 32'd2);
    send_word(32'd9);
    check("blk_count_after_b1", blk_count, 32'd2);
    check("wrap_after_b1", 32'(wrap_cnt), 32'd1);
    send_word(32'd10);
    mst_buffer_full = 1'b1;
    fork
      begin
        send_word(32'd11);
        send_word(32'd12);
      end
      begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("full_in_ready", 32'(in_ready), 32'd0);
          check("full_write", 32'(mst_write_buffer), 32'd0);
        end
        @(posedge clk);
        #1 mst_buffer_full = 1'b0;
      end
    join

    // enable dropped mid-block: block still completes, then IDLE
    start_block(1, 32'd3);
    send_word(32'd13);
    send_word(32'd14);
    enable = 1'b0;
    send_word(32'd15);
    send_word(32'd16);
    wait_idle();
    repeat (10) @(negedge clk);
    check("stop_blk_count", blk_count, 32'd4);
    check("stop_wrap_cnt", 32'(wrap_cnt), 32'd2);
    check("stop_state", 32'(dbg_state), 32'(IDLE));
    check("stop_base", mst_write_base, 32'(1 * WPB * 4));

    // reset during STREAM
    @(posedge clk);
    #1 enable = 1'b1;
    start_block(0, 32'd4);
    send_word(32'd17);
    send_word(32'd18);
    reset_reset = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1 reset_reset = 1'b0;
    @(negedge clk);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_go", 32'(mst_go), 32'd0);
    check("mid_rst_blk_count", blk_count, 32'd0);
    check("mid_rst_base", mst_write_base, 32'd0);

    // recovery block after reset starts again at ring base
    @(posedge clk);
    #1 enable = 1'b1;
    start_block(0, 32'd0);
    send_word(32'd21);
    send_word(32'd22);
    enable = 1'b0;
    send_word(32'd23);
    send_word(32'd24);
    wait_idle();
    check("recov_blk_count", blk_count, 32'd1);
    check("recov_wrap_cnt", 32'(wrap_cnt), 32'd2);

    repeat (5) @(negedge clk);
    check("data_q_drained", 32'(exp_q.size()), 32'd0);
    check("base_q_drained", 32'(exp_base_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sdram_block_feeder.md
Name: sdram_block_feeder

Overview:
- Upstream stage of the SDRAM write master in the soft-processor system.
- Accepts a 32-bit sample stream from the crate-interface capture logic and packs it into fixed-size blocks.
- For each block it programs the master's control port (base, length, go), pushes the words into the master's user buffer under buffer_full backpressure, then waits for done.
- Block base addresses advance through a ring region in SDRAM; the soft processor reads completed blocks via blk_count.

Parameters:
- BLOCK_WORDS, 256, data words per block; must be >= 2.
- RING_BASE, 32'h0000_0000, byte address of ring start; 4-byte aligned.
- RING_BLOCKS, 1024, blocks in ring before the base address wraps to RING_BASE.

Ports:
- clk_clk  in  1  system clock, same as master clock.
- reset_reset  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = capture blocks, 0 = stop after the current block.
- in_valid  in  1  sample valid.
- in_data  in  32  sample word.
- in_ready  out  1  sample accepted when in_valid & in_ready.
- mst_fixed_location  out  1  to master control_fixed_location; constant 0.
- mst_write_base  out  32  to master control_write_base.
- mst_write_length  out  32  to master control_write_length, in bytes.
- mst_go  out  1  to master control_go; single-cycle pulse.
- mst_done  in  1  from master control_done.
- mst_write_buffer  out  1  to master user_write_buffer.
- mst_buffer_data  out  32  to master user_buffer_input_data.
- mst_buffer_full  in  1  from master user_buffer_full.
- busy  out  1  1 in any state other than IDLE.
- blk_count  out  32  blocks completed since reset; wraps modulo 2^32.
- ring_wrap  out  1  one-cycle pulse when the block index wraps to 0.

Behaviour:
- Clock and reset: single clock clk_clk; reset_reset is synchronous and active-high.
- Reset values: state=IDLE, blk_idx=0, word_cnt=0, blk_count=0, mst_go=0, mst_write_buffer=0, in_ready=0, busy=0, ring_wrap=0, mst_write_base=RING_BASE, mst_write_length=BLOCK_WORDS*4, mst_buffer_data=0.
- State machine:
  - IDLE: if enable=1, go to LAUNCH.
  - LAUNCH (1 cycle): mst_write_base = RING_BASE + blk_idx*BLOCK_WORDS*4, mst_write_length = BLOCK_WORDS*4, mst_go=1; next state STREAM.
  - STREAM: in_ready = ~mst_buffer_full.
    - Pass-through: mst_write_buffer = in_valid & in_ready, mst_buffer_data = in_data (combinational, zero latency).
    - word_cnt increments on each accepted word.
    - When the accepted word is number BLOCK_WORDS, go to WAIT_DONE and clear word_cnt.
  - WAIT_DONE: in_ready=0. When mst_done=1:
    - blk_count += 1.
    - blk_idx = (blk_idx == RING_BLOCKS-1) ? 0 : blk_idx+1; ring_wrap=1 for that cycle if it wrapped.
    - Go to LAUNCH if enable=1, else IDLE.
- mst_done is ignored outside WAIT_DONE. Because WAIT_DONE is entered at least BLOCK_WORDS cycles after go, a stale done value cannot end the block early.
- in_ready is 0 in IDLE, LAUNCH and WAIT_DONE. Upstream must hold in_valid/in_data until accepted; no data is dropped by this block.
- enable falling mid-block: the current block completes fully (all BLOCK_WORDS words plus done). No partial blocks are ever written.
- mst_buffer_full and in_valid asserted in the same cycle: no transfer; word_cnt holds.
- mst_write_base and mst_write_length are registered, change only in LAUNCH, and stay stable until the next LAUNCH.
- Address arithmetic is 32-bit unsigned; the designer guarantees RING_BASE + RING_BLOCKS*BLOCK_WORDS*4 <= 2^32.
- Reset mid-operation: returns to IDLE immediately; the partial block is abandoned. The master is reset separately by the system reset.

Optional Feature:
- Macro: SDRAM_FEEDER_HEADER_EN.
- Defined:
  - Each block starts with one header word {16'hB10C, blk_count[15:0]}, written in a HDR state between LAUNCH and STREAM.
  - HDR writes when mst_buffer_full=0, with in_ready=0.
  - Block length becomes (BLOCK_WORDS+1)*4 bytes and the block stride becomes (BLOCK_WORDS+1)*4.
- Undefined: no HDR state; length and stride are BLOCK_WORDS*4.

Decomposition:
- Package sdram_feeder_pkg:
  - state enum {IDLE, LAUNCH, HDR, STREAM, WAIT_DONE}.
  - HDR_TAG = 16'hB10C.
  - Function blk_bytes(words, hdr) returning the block length in bytes.
- One sub-module, sdram_ring_addr_gen: holds blk_idx, computes the base address, and produces the wrap pulse on an advance strobe.

Test Plan:
- BLOCK_WORDS=4, enable=1, in_valid always 1 with data 1..8, mst_done pulsed 3 cycles after each 4th word -> two go pulses, bases 0x0 and 0x10, length 16, buffer data 1..4 then 5..8, blk_count=2.
- mst_buffer_full held 1 for 5 cycles mid-block -> in_ready=0 and no writes for those cycles; word order preserved; still exactly 4 writes per block.
- RING_BLOCKS=2, run 3 blocks -> bases 0x0, 0x10, 0x0; ring_wrap pulses once, after block 2 done.
- enable dropped after word 2 of a block -> words 3 and 4 still accepted, done awaited, then IDLE with busy=0 and no further go.
- reset_reset asserted during STREAM -> next cycle state=IDLE, in_ready=0, mst_go=0, blk_count=0, base=RING_BASE.
- SDRAM_FEEDER_HEADER_EN defined, BLOCK_WORDS=4 -> length 20; first written word 0xB10C0000, second block header 0xB10C0001; second base 0x14.
